// File: rtl/udc_pkg.sv
// Shared types and constants for the bounded up/down counter.
// Direction encoding and saturate/wrap mode values.
package udc_pkg;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    localparam logic SAT_MODE  = 1'b1;
    localparam logic WRAP_MODE = 1'b0;

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-count calculation for the bounded up/down counter.
// Ports: count, step, dir, min_val, max_val, sat in; nxt, crossed_max, crossed_min out.
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  dir_e              dir,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              sat,
    output logic [WIDTH-1:0]  nxt,
    output logic              crossed_max,
    output logic              crossed_min
);

    // One extra bit keeps the carry so a sum past 2^WIDTH is still seen.
    logic [WIDTH:0] sum_up;
    // Two extra bits: room for the carry plus a sign for negative results.
    logic signed [WIDTH+1:0] diff_dn;
    logic signed [WIDTH+1:0] min_s;

    assign sum_up  = (WIDTH+1)'(count) + (WIDTH+1)'(step);
    assign diff_dn = $signed((WIDTH+2)'(count)) - $signed((WIDTH+2)'(step));
    assign min_s   = $signed((WIDTH+2)'(min_val));

    always_comb begin
        nxt         = count;
        crossed_max = 1'b0;
        crossed_min = 1'b0;
        // A zero step holds even when count is outside the bounds.
        if (step != '0) begin
            if (dir == DIR_UP) begin
                if (sum_up > (WIDTH+1)'(max_val)) begin
                    crossed_max = 1'b1;
                    nxt = (sat == WRAP_MODE) ? min_val : max_val;
                end else begin
                    nxt = sum_up[WIDTH-1:0];
                end
            end else begin
                if (diff_dn < min_s) begin
                    crossed_min = 1'b1;
                    nxt = (sat == WRAP_MODE) ? max_val : min_val;
                end else begin
                    nxt = diff_dn[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/bounded_updown_counter.sv
// Up/down counter with load, runtime bounds, step, saturate/wrap and ovf/unf pulses.
// Ports: clk, rst_n, en, m, load, data_in, step, min_val, max_val, sat in;
// count, at_min, at_max, ovf, unf, cfg_err out. Macro UDC_BOUNCE_EN adds input
// bounce and a direction FSM that reverses at the bounds.
module bounded_updown_counter
    import udc_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STEP_W  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              m,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              sat,
`ifdef UDC_BOUNCE_EN
    input  logic              bounce,
`endif
    output logic [WIDTH-1:0]  count,
    output logic              at_min,
    output logic              at_max,
    output logic              ovf,
    output logic              unf,
    output logic              cfg_err
);

    logic [WIDTH-1:0] count_q;
    logic             ovf_q;
    logic             unf_q;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nxt;
    logic             crossed_max;
    logic             crossed_min;
    dir_e             dir;
    logic             sat_eff;

    assign cfg_err = (min_val > max_val);
    assign at_min  = (count_q == min_val);
    assign at_max  = (count_q == max_val);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    assign load_val = (data_in < min_val) ? min_val :
                      (data_in > max_val) ? max_val : data_in;

`ifdef UDC_BOUNCE_EN
    dir_e dir_q;
    dir_e dir_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    always_comb begin
        dir_d = dir_q;
        if (!cfg_err && load) begin
            dir_d = DIR_UP;
        end else if (!bounce) begin
            dir_d = dir_e'(m);
        end else if (!cfg_err && en && crossed_max) begin
            dir_d = DIR_DN;
        end else if (!cfg_err && en && crossed_min) begin
            dir_d = DIR_UP;
        end
    end

    // Bouncing always stops at the bound, then the FSM turns around.
    assign dir     = bounce ? dir_q : dir_e'(m);
    assign sat_eff = bounce ? SAT_MODE : sat;
`else
    assign dir     = dir_e'(m);
    assign sat_eff = sat;
`endif

    udc_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count       (count_q),
        .step        (step),
        .dir         (dir),
        .min_val     (min_val),
        .max_val     (max_val),
        .sat         (sat_eff),
        .nxt         (nxt),
        .crossed_max (crossed_max),
        .crossed_min (crossed_min)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (!cfg_err) begin
                if (load) begin
                    count_q <= load_val;
                end else if (en) begin
                    count_q <= nxt;
                    ovf_q   <= crossed_max;
                    unf_q   <= crossed_min;
                end
            end
        end
    end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed self-checking bench for bounded_updown_counter.
// Bounce sequence is exercised when UDC_BOUNCE_EN is defined.
module tb_bounded_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       m;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] step;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic       sat;
    logic       bounce;
    logic [7:0] count;
    logic       at_min;
    logic       at_max;
    logic       ovf;
    logic       unf;
    logic       cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bounded_updown_counter #(
        .WIDTH   (8),
        .STEP_W  (4),
        .RST_VAL (8'd0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .m       (m),
        .load    (load),
        .data_in (data_in),
        .step    (step),
        .min_val (min_val),
        .max_val (max_val),
        .sat     (sat),
`ifdef UDC_BOUNCE_EN
        .bounce  (bounce),
`endif
        .count   (count),
        .at_min  (at_min),
        .at_max  (at_max),
        .ovf     (ovf),
        .unf     (unf),
        .cfg_err (cfg_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b1; data_in = 8'd9; en = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
        n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL rst_flags got ovf=%b unf=%b exp 0 0", ovf, unf); end
        rst_n = 1'b1; en = 1'b0;
        tick();
        n_cmp++; if (count !== 8'd9) begin n_err++; $display("FAIL rst_then_load got %0d exp 9", count); end
        load = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd9) begin n_err++; $display("FAIL rst_glitch got %0d exp 9", count); end
    endtask

    task automatic test_basic();
        min_val = 8'd0; max_val = 8'd255; sat = 1'b1;
        load = 1'b1; data_in = 8'd5;
        tick();
        n_cmp++; if (count !== 8'd5) begin n_err++; $display("FAIL basic_load got %0d exp 5", count); end
        load = 1'b0; en = 1'b1; m = 1'b0; step = 4'd1;
        tick();
        n_cmp++; if (count !== 8'd6) begin n_err++; $display("FAIL basic_up got %0d exp 6", count); end
        m = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd5) begin n_err++; $display("FAIL basic_dn got %0d exp 5", count); end
        step = 4'd0;
        tick();
        n_cmp++; if (count !== 8'd5 || ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL basic_step0 got %0d/%b/%b exp 5/0/0", count, ovf, unf); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        min_val = 8'd10; max_val = 8'd20; sat = 1'b1;
        load = 1'b1; data_in = 8'd18;
        tick();
        load = 1'b0; en = 1'b1; m = 1'b0; step = 4'd3;
        tick();
        n_cmp++; if (count !== 8'd20 || ovf !== 1'b1) begin n_err++; $display("FAIL sat_hit got %0d ovf=%b exp 20 1", count, ovf); end
        n_cmp++; if (at_max !== 1'b1 || at_min !== 1'b0) begin n_err++; $display("FAIL sat_atmax got %b/%b exp 1/0", at_max, at_min); end
        tick();
        n_cmp++; if (count !== 8'd20 || ovf !== 1'b1) begin n_err++; $display("FAIL sat_repeat got %0d ovf=%b exp 20 1", count, ovf); end
        m = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd17 || ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL sat_down got %0d/%b/%b exp 17/0/0", count, ovf, unf); end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        sat = 1'b0;
        load = 1'b1; data_in = 8'd19;
        tick();
        load = 1'b0; en = 1'b1; m = 1'b0; step = 4'd3;
        tick();
        n_cmp++; if (count !== 8'd10 || ovf !== 1'b1) begin n_err++; $display("FAIL wrap_up got %0d ovf=%b exp 10 1", count, ovf); end
        n_cmp++; if (at_min !== 1'b1) begin n_err++; $display("FAIL wrap_atmin got %b exp 1", at_min); end
        en = 1'b0;
        tick();
        n_cmp++; if (count !== 8'd10 || ovf !== 1'b0) begin n_err++; $display("FAIL wrap_pulse got %0d ovf=%b exp 10 0", count, ovf); end
        load = 1'b1; data_in = 8'd11;
        tick();
        load = 1'b0; en = 1'b1; m = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd20 || unf !== 1'b1 || ovf !== 1'b0) begin n_err++; $display("FAIL wrap_dn got %0d/%b/%b exp 20/1/0", count, unf, ovf); end
        en = 1'b0;
        tick();
        n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL wrap_unf_pulse got %b exp 0", unf); end
    endtask

    task automatic test_clamp();
        min_val = 8'd10; max_val = 8'd20;
        load = 1'b1; en = 1'b1; m = 1'b0; step = 4'd1; data_in = 8'd25;
        tick();
        n_cmp++; if (count !== 8'd20 || ovf !== 1'b0) begin n_err++; $display("FAIL clamp_hi got %0d ovf=%b exp 20 0", count, ovf); end
        data_in = 8'd3;
        tick();
        n_cmp++; if (count !== 8'd10 || unf !== 1'b0) begin n_err++; $display("FAIL clamp_lo got %0d unf=%b exp 10 0", count, unf); end
        min_val = 8'd30; data_in = 8'd15;
        #1;
        n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err got %b exp 1", cfg_err); end
        tick();
        n_cmp++; if (count !== 8'd10 || ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL cfg_hold got %0d/%b/%b exp 10/0/0", count, ovf, unf); end
        load = 1'b0;
        tick();
        n_cmp++; if (count !== 8'd10) begin n_err++; $display("FAIL cfg_hold_en got %0d exp 10", count); end
        min_val = 8'd10;
        #1;
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_clear got %b exp 0", cfg_err); end
        en = 1'b0;
    endtask

    task automatic test_out_of_range();
        min_val = 8'd10; max_val = 8'd20; sat = 1'b1;
        load = 1'b1; data_in = 8'd15;
        tick();
        load = 1'b0; max_val = 8'd12; en = 1'b1; m = 1'b0; step = 4'd1;
        tick();
        n_cmp++; if (count !== 8'd12 || ovf !== 1'b1) begin n_err++; $display("FAIL oor_up got %0d ovf=%b exp 12 1", count, ovf); end
        max_val = 8'd20; min_val = 8'd14; sat = 1'b0; m = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd20 || unf !== 1'b1) begin n_err++; $display("FAIL oor_dn got %0d unf=%b exp 20 1", count, unf); end
        min_val = 8'd10; step = 4'd15; sat = 1'b1;
        tick();
        n_cmp++; if (count !== 8'd10 || unf !== 1'b1) begin n_err++; $display("FAIL oor_dn_sat got %0d unf=%b exp 10 1", count, unf); end
        en = 1'b0;
    endtask

    task automatic test_bounce();
`ifdef UDC_BOUNCE_EN
        logic [7:0] exp_c [7];
        logic       exp_o [7];
        logic       exp_u [7];
        exp_c = '{8'd2, 8'd4, 8'd4, 8'd2, 8'd0, 8'd0, 8'd2};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_u = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        min_val = 8'd0; max_val = 8'd4; sat = 1'b0; bounce = 1'b1;
        load = 1'b1; data_in = 8'd0; m = 1'b1;
        tick();
        load = 1'b0; en = 1'b1; step = 4'd2;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if (count !== exp_c[i] || ovf !== exp_o[i] || unf !== exp_u[i]) begin
                n_err++;
                $display("FAIL bounce[%0d] got %0d/%b/%b exp %0d/%b/%b", i, count, ovf, unf, exp_c[i], exp_o[i], exp_u[i]);
            end
        end
        en = 1'b0; bounce = 1'b0;
`endif
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; m = 1'b0; load = 1'b0; data_in = '0;
        step = '0; min_val = 8'd0; max_val = 8'd255; sat = 1'b1; bounce = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_wrap();
        test_clamp();
        test_out_of_range();
        test_bounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bounded_updown_counter.md
Name: bounded_updown_counter

Overview:
Parametrised up/down counter with synchronous load and runtime-programmable lower/upper bounds. Supports a configurable step, and either saturating or wrapping behaviour at the bounds. Overflow and underflow events are flagged as single-cycle pulses. It is the general-purpose counter for timers, credit counters and address generators, replacing the fixed 8-bit load/enable/mode counter.

Parameters:
WIDTH, 8, counter/data/bound width in bits
STEP_W, 4, width of the step input
RST_VAL, 0, count value forced by reset (WIDTH bits, unconditional, not clamped)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
en  in  1  counting enable
m  in  1  counting mode: 0 = up, 1 = down
load  in  1  synchronous load of data_in
data_in  in  WIDTH  value to load
step  in  STEP_W  increment/decrement magnitude, unsigned
min_val  in  WIDTH  lower bound, inclusive
max_val  in  WIDTH  upper bound, inclusive
sat  in  1  1 = saturate at bound, 0 = wrap to opposite bound
count  out  WIDTH  registered count value
at_min  out  1  combinational: count == min_val
at_max  out  1  combinational: count == max_val
ovf  out  1  registered pulse: last update crossed max_val
unf  out  1  registered pulse: last update crossed min_val
cfg_err  out  1  combinational: min_val > max_val

Behaviour:
- Reset: rst_n sampled only at posedge. At that edge: count = RST_VAL, ovf = 0, unf = 0. Reset dominates load and en.
- Priority per edge: rst_n low > cfg_err > load > en > hold.
- cfg_err = 1: load and en are ignored, count holds, and ovf = unf = 0.
- Load: count = data_in clamped into [min_val, max_val]. Clamping never raises ovf or unf.
- Count up (en = 1, m = 0):
  - nxt = count + step, computed in WIDTH+1 bits.
  - If nxt <= max_val: count = nxt.
  - Else if sat = 1: count = max_val, ovf = 1.
  - Else (sat = 0): count = min_val, ovf = 1.
- Count down (en = 1, m = 1):
  - nxt = count - step, computed in signed WIDTH+2 bits.
  - If nxt >= min_val: count = nxt.
  - Else if sat = 1: count = min_val, unf = 1.
  - Else (sat = 0): count = max_val, unf = 1.
- Repeated saturation: in saturate mode, a blocked step at the bound re-asserts ovf/unf on every enabled cycle.
- Out-of-range count (e.g. after reset or a bound change): comparisons use the current bounds. Above max while counting up is overflow; below min while counting down is underflow.
- step = 0 with en = 1: count holds, and ovf = unf = 0.
- ovf and unf are cleared on every edge where no crossing occurs, so they are exactly 1 cycle wide.
- Latency: inputs to count is one clock edge.
- Flags: at_min, at_max and cfg_err are decoded from the registered count and the current bounds; they have no register delay.

Optional Feature:
Macro UDC_BOUNCE_EN.
- Defined:
  - Adds input port bounce (1 bit) and internal direction FSM with states DIR_UP and DIR_DN; reset state is DIR_UP.
  - When bounce = 1, m is ignored and direction comes from the FSM.
  - On an enabled step that would cross max_val: count = max_val, ovf = 1, FSM goes to DIR_DN.
  - On an enabled step that would cross min_val: count = min_val, unf = 1, FSM goes to DIR_UP. sat is ignored in both cases.
  - Load forces the FSM to DIR_UP.
  - When bounce = 0, the FSM is held in step with m.
- Not defined: no bounce port and no FSM; behaviour is exactly as described above.

Decomposition:
- Package udc_pkg:
  - typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e.
  - localparam SAT_MODE = 1'b1, WRAP_MODE = 1'b0.
- Sub-module udc_next_calc, purely combinational:
  - Inputs: count, step, direction, bounds, sat.
  - Outputs: next count, crossed_max, crossed_min.
- The top module holds the count, ovf/unf and direction FSM registers.

Test Plan:
- rst_n = 0 held over one posedge with load = 1 and data_in = 9 -> count = 0, ovf = unf = 0. rst_n pulsed low between edges only -> no effect.
- min = 0, max = 255, load 5 -> 5; en = 1, m = 0, step = 1 -> 6; m = 1 -> 5; step = 0 -> stays 5, no flags.
- min = 10, max = 20, sat = 1, load 18, up, step = 3 -> 20 with ovf = 1; next cycle 20 with ovf = 1; then down step 3 -> 17 with ovf = 0.
- sat = 0, load 19, up, step 3 -> 10 with ovf = 1 (single cycle). Load 11, down, step 3 -> 20 with unf = 1.
- load = 1, en = 1, data_in = 25, max = 20 -> count = 20, no ovf. data_in = 3, min = 10 -> 10. min = 30, max = 20 -> cfg_err = 1, count holds.
- UDC_BOUNCE_EN, bounce = 1, min = 0, max = 4, step = 2, from 0 -> 2, 4, 4 (ovf, now DN), 2, 0, 0 (unf, now UP), 2.
